// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the data-cache sequencing controller.
package cache_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 10;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_OFFSET         = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEF_CNT_WIDTH      = 32;
  localparam int unsigned DEF_TO_CNT_WIDTH   = $clog2(DEF_TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } state_e;

  // Width needed to hold the values 0..timeout inclusive.
  function automatic int unsigned to_cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter for an outstanding memory transaction.
module mem_timeout_cnt
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = to_cnt_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear while no transaction is waiting; count waiting cycles up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, 4-word-block, write-through,
// no-write-allocate data cache. Optional hit/miss statistics are built when
// the macro CACHE_STATS_EN is defined; otherwise hit_cnt/miss_cnt read 0.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned OFFSET         = DEF_OFFSET,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  stall,
  input  logic                  cache_miss,
  output logic                  cache_rd,
  output logic                  cache_wr,
  output logic                  cache_block_wr,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic                  mem_err,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  waiting;
  logic                  to_expired;
  logic                  timed_out;
  logic                  wr_done;

  assign waiting   = (state_q == FETCH) || (state_q == WRITE);
  assign timed_out = waiting && to_expired;
  // A write completes on mem_ready unless the timeout already fired.
  assign wr_done   = (state_q == WRITE) && !to_expired && mem_ready;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (CLK),
    .rst      (rst),
    .clr_i    (!waiting),
    .en_i     (waiting && !mem_ready),
    .expired_o(to_expired)
  );

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a store takes priority over a concurrent load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          state_d = WRITE;
        end else if (cpu_rd && cache_miss) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (timed_out) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      WRITE: begin
        if (timed_out || mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    stall          = 1'b0;
    cache_rd       = 1'b0;
    cache_wr       = 1'b0;
    cache_block_wr = 1'b0;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;
    mem_err        = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          stall    = cpu_wr | (cpu_rd & cache_miss);
          cache_rd = cpu_rd | cpu_wr;
        end
        FETCH: begin
          stall      = 1'b1;
          mem_rd_req = !to_expired;
          mem_err    = to_expired;
        end
        FILL: begin
          stall          = 1'b1;
          cache_block_wr = 1'b1;
        end
        WRITE: begin
          cache_rd   = cpu_rd | cpu_wr;
          mem_wr_req = !to_expired;
          mem_err    = to_expired;
          stall      = !wr_done;
          cache_wr   = wr_done && !cache_miss;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  // Capture the memory address/data when leaving IDLE; reads are block aligned.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE) begin
      if (cpu_wr) begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
      end else if (cpu_rd && cache_miss) begin
        addr_d = {cpu_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
      end
    end
  end

  // Memory address/data registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef CACHE_STATS_EN
  logic                 refill_q;
  logic [CNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d;
  logic                 hit_ev, miss_ev;

  // Classify request completions; the probe right after a fill is not a new hit.
  always_comb begin
    hit_ev  = 1'b0;
    miss_ev = 1'b0;
    if (state_q == IDLE) begin
      hit_ev  = cpu_rd && !cpu_wr && !cache_miss && !refill_q;
      miss_ev = cpu_rd && !cpu_wr && cache_miss;
    end else if (wr_done) begin
      hit_ev  = !cache_miss;
      miss_ev = cache_miss;
    end
  end

  // Saturating increments.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_ev && (hit_q != {CNT_WIDTH{1'b1}})) begin
      hit_d = hit_q + CNT_WIDTH'(1);
    end
    if (miss_ev && (miss_q != {CNT_WIDTH{1'b1}})) begin
      miss_d = miss_q + CNT_WIDTH'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      hit_q    <= '0;
      miss_q   <= '0;
      refill_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      refill_q <= (state_q == FILL);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl with a cache/memory environment
// and a transaction-level reference model.
module tb_cache_ctrl;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned OFF = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned CW  = 32;

  logic          CLK = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          stall, cache_miss, cache_rd, cache_wr, cache_block_wr;
  logic          mem_rd_req, mem_wr_req, mem_ready, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 CLK = ~CLK;

  cache_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET(OFF),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .stall(stall),
    .cache_miss(cache_miss), .cache_rd(cache_rd), .cache_wr(cache_wr),
    .cache_block_wr(cache_block_wr), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_err(mem_err), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  // Environment: 16-line direct-mapped cache (idx=addr[5:2], tag=addr[9:6]) and memory.
  logic          env_valid [16];
  logic [3:0]    env_tag   [16];
  logic [DW-1:0] env_data  [16][4];
  logic [DW-1:0] env_mem   [1024];

  // Reference model state.
  logic          ref_valid [16];
  logic [3:0]    ref_tag   [16];
  logic [DW-1:0] ref_mem   [1024];
  int            exp_hit, exp_miss;

  int n_chk, n_err;
  int mem_lat, mem_wait;
  bit noise_en;

  // Sampled outputs of the last cycle.
  logic          s_stall, s_rd_req, s_wr_req, s_bw, s_cw, s_err, s_crd, s_mready;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  int            both_req;

  // Per-request observations.
  int            r_stall, r_rdreq, r_bw, r_cw, r_err, r_wr_done;
  logic [AW-1:0] r_rd_addr, r_wr_addr;
  logic [DW-1:0] r_wr_data;

  always_comb cache_miss = !(env_valid[cpu_addr[5:2]] && (env_tag[cpu_addr[5:2]] == cpu_addr[9:6]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_hit(input logic [AW-1:0] a);
    return ref_valid[a[5:2]] && (ref_tag[a[5:2]] == a[9:6]);
  endfunction

  function automatic logic env_res(input logic [AW-1:0] a);
    return env_valid[a[5:2]] && (env_tag[a[5:2]] == a[9:6]);
  endfunction

  // One clock: drive mem_ready, sample at mid-cycle, update environment at the edge.
  task automatic tick();
    @(negedge CLK);
    if (mem_rd_req || mem_wr_req) begin
      mem_wait++;
      mem_ready = (mem_lat != 0) && (mem_wait == mem_lat);
    end else begin
      mem_wait  = 0;
      mem_ready = noise_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    #1;
    s_stall = stall;  s_rd_req = mem_rd_req; s_wr_req = mem_wr_req;
    s_bw = cache_block_wr; s_cw = cache_wr; s_err = mem_err; s_crd = cache_rd;
    s_mready = mem_ready; s_addr = mem_addr; s_wdata = mem_wdata;
    if (mem_rd_req && mem_wr_req) both_req++;
    @(posedge CLK);
    if (s_bw) begin
      env_valid[cpu_addr[5:2]] = 1'b1;
      env_tag[cpu_addr[5:2]]   = cpu_addr[9:6];
      for (int k = 0; k < 4; k++)
        env_data[cpu_addr[5:2]][k] = env_mem[{cpu_addr[9:2], 2'(k)}];
    end
    if (s_cw) env_data[cpu_addr[5:2]][cpu_addr[1:0]] = cpu_wdata;
    if (s_wr_req && s_mready) env_mem[s_addr] = s_wdata;
    #1;
    mem_ready = 1'b0;
  endtask

  // Present one request and run until the processor sees stall=0.
  task automatic run_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int lat);
    logic done;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; mem_lat = lat;
    r_stall = 0; r_rdreq = 0; r_bw = 0; r_cw = 0; r_err = 0; r_wr_done = 0;
    r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (s_stall) r_stall++;
      if (s_rd_req) begin r_rdreq++; r_rd_addr = s_addr; end
      if (s_wr_req && s_mready) begin r_wr_done++; r_wr_addr = s_addr; r_wr_data = s_wdata; end
      if (s_bw) r_bw++;
      if (s_cw) r_cw++;
      if (s_err) r_err++;
      if (!s_stall) done = 1'b1;
    end
    if (!done) check("req_budget", 64'(done), 64'(1));
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check("hit_cnt",  64'(hit_cnt),  64'(exp_hit));
    check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
`else
    check("hit_cnt",  64'(hit_cnt),  64'(0));
    check("miss_cnt", 64'(miss_cnt), 64'(0));
`endif
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input int lat);
    logic          hit;
    logic [AW-1:0] blk;
    hit = ref_hit(a);
    blk = {a[AW-1:OFF], {OFF{1'b0}}};
    run_req(1'b1, 1'b0, a, '0, lat);
    check("rd_stall",   64'(r_stall), hit ? 64'(0) : 64'(lat + 2));
    check("rd_memreq",  64'(r_rdreq), hit ? 64'(0) : 64'(lat));
    if (!hit) check("rd_addr", 64'(r_rd_addr), 64'(blk));
    check("rd_blkwr",   64'(r_bw), hit ? 64'(0) : 64'(1));
    check("rd_cachewr", 64'(r_cw), 64'(0));
    check("rd_probe",   64'(s_crd), 64'(1));
    if (hit) exp_hit++;
    else begin
      exp_miss++;
      ref_valid[a[5:2]] = 1'b1;
      ref_tag[a[5:2]]   = a[9:6];
    end
    check("rd_resident", 64'(env_res(a)), 64'(ref_hit(a)));
    check("rd_data", 64'(env_data[a[5:2]][a[1:0]]), 64'(ref_mem[a]));
    check_stats();
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat,
                       input logic rd_too);
    logic hit;
    hit = ref_hit(a);
    run_req(rd_too, 1'b1, a, d, lat);
    check("wr_stall",   64'(r_stall), 64'(lat));
    check("wr_done",    64'(r_wr_done), 64'(1));
    check("wr_addr",    64'(r_wr_addr), 64'(a));
    check("wr_data",    64'(r_wr_data), 64'(d));
    check("wr_cachewr", 64'(r_cw), 64'(hit));
    check("wr_blkwr",   64'(r_bw), 64'(0));
    check("wr_rdreq",   64'(r_rdreq), 64'(0));
    ref_mem[a] = d;
    if (hit) exp_hit++; else exp_miss++;
    check("wr_mem", 64'(env_mem[a]), 64'(ref_mem[a]));
    check("wr_resident", 64'(env_res(a)), 64'(ref_hit(a)));
    if (hit) check("wr_cdata", 64'(env_data[a[5:2]][a[1:0]]), 64'(d));
    check_stats();
  endtask

  // Read miss with a silent memory: expect a timeout, then a retry that completes.
  task automatic do_timeout(input logic [AW-1:0] a);
    int   err_at, rdreq_before, bw, errs;
    logic stall_at_err, rdreq_at_err, rd_after1, rd_after2, done;
    err_at = -1; rdreq_before = 0; bw = 0; errs = 0;
    stall_at_err = 1'b0; rdreq_at_err = 1'b1; rd_after1 = 1'b1; rd_after2 = 1'b0;
    done = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a; mem_lat = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (err_at < 0 && s_rd_req) rdreq_before++;
      if (s_err) errs++;
      if (s_bw) bw++;
      if (err_at >= 0 && i == err_at + 1) rd_after1 = s_rd_req;
      if (err_at >= 0 && i == err_at + 2) rd_after2 = s_rd_req;
      if (s_err && err_at < 0) begin
        err_at = i; stall_at_err = s_stall; rdreq_at_err = s_rd_req; mem_lat = 2;
      end
      if (!s_stall) done = 1'b1;
    end
    check("to_err_cycle",   64'(err_at), 64'(TO + 1));
    check("to_wait_cycles", 64'(rdreq_before), 64'(TO));
    check("to_err_stall",   64'(stall_at_err), 64'(1));
    check("to_err_reqdrop", 64'(rdreq_at_err), 64'(0));
    check("to_idle_after",  64'(rd_after1), 64'(0));
    check("to_refetch",     64'(rd_after2), 64'(1));
    check("to_err_pulses",  64'(errs), 64'(1));
    check("to_done",        64'(done), 64'(1));
    check("to_blkwr",       64'(bw), 64'(1));
    exp_miss += 2;
    ref_valid[a[5:2]] = 1'b1;
    ref_tag[a[5:2]]   = a[9:6];
    check_stats();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            bw_after;
    n_chk = 0; n_err = 0; exp_hit = 0; exp_miss = 0;
    mem_lat = 0; mem_wait = 0; noise_en = 1'b0; both_req = 0;
    for (int i = 0; i < 16; i++) begin
      env_valid[i] = 1'b0; env_tag[i] = '0; ref_valid[i] = 1'b0; ref_tag[i] = '0;
      for (int k = 0; k < 4; k++) env_data[i][k] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_ready = 1'b0;
    tick(); tick();
    check("rst_stall",  64'(s_stall), 64'(0));
    check("rst_rdreq",  64'(s_rd_req), 64'(0));
    check("rst_wrreq",  64'(s_wr_req), 64'(0));
    check("rst_addr",   64'(s_addr), 64'(0));
    check("rst_wdata",  64'(s_wdata), 64'(0));
    check("rst_blkwr",  64'(s_bw), 64'(0));
    check("rst_err",    64'(s_err), 64'(0));
    check_stats();
    rst = 1'b0;
    tick();

    // Read miss then hit in the same block.
    do_rd(10'h045, 3);
    do_rd(10'h046, 1);
    // Write hit, then read back.
    do_wr(10'h047, 32'hDEADBEEF, 2, 1'b0);
    do_rd(10'h047, 1);
    check("wr_hit_readback", 64'(env_data[1][3]), 64'(32'hDEADBEEF));
    // Write miss leaves the cache alone; a later read misses.
    do_wr(10'h3C0, 32'h0BADF00D, 3, 1'b0);
    do_rd(10'h3C0, 2);
    // Timeout and retry.
    do_timeout(10'h280);
    // Simultaneous read and write to a resident address: write first, then the read.
    do_wr(10'h045, 32'h12345678, 1, 1'b1);
    do_rd(10'h045, 1);

    // Randomized traffic with spurious mem_ready while no request is pending.
    noise_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 2))
        0: do_rd(a, int'($urandom_range(1, 4)));
        1: do_wr(a, $urandom, int'($urandom_range(1, 4)), 1'b0);
        default: begin
          do_wr(a, $urandom, int'($urandom_range(1, 4)), 1'b1);
          do_rd(a, int'($urandom_range(1, 4)));
        end
      endcase
    end
    noise_en = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();
    check("never_both_req", 64'(both_req), 64'(0));

    // Asynchronous reset in the middle of a fetch.
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h3F4; mem_lat = 0;
    tick(); tick(); tick();
    check("pre_rst_fetch", 64'(s_rd_req), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_rdreq", 64'(mem_rd_req), 64'(0));
    check("arst_stall", 64'(stall), 64'(0));
    check("arst_probe", 64'(cache_rd), 64'(0));
    check("arst_addr",  64'(mem_addr), 64'(0));
    check("arst_blkwr", 64'(cache_block_wr), 64'(0));
    exp_hit = 0; exp_miss = 0;
    check_stats();
    tick();
    rst = 1'b0; cpu_rd = 1'b0; mem_lat = 1;
    bw_after = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_bw) bw_after++;
    end
    check("post_rst_blkwr", 64'(bw_after), 64'(0));
    do_rd(10'h3F4, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
